// File: rtl/fnd_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Stages loaded values and commits them only at frame boundaries; one digit per refresh slot.
module fnd_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter int BLANK_LZ    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [3:0]            nibble,
    output logic                  blank,
    output logic [DIGITS-1:0]     digit_en_n,
    output logic                  dp_n,
    output logic                  pending,
    output logic                  frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_V    = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // Digit i (i > 0) is blanked when it and every digit to its left are zero.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [DIGITS-1:0][3:0] v);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (v[i] == 4'h0);
            m[i]       = zero_above & (BLANK_LZ != 0);
        end
        return m;
    endfunction

    logic [PW-1:0]            presc_r, presc_s;
    logic [IW-1:0]            idx_r, idx_s;
    logic [DIGITS-1:0][3:0]   disp_val_r, disp_val_s;
    logic [DIGITS-1:0]        disp_dp_r, disp_dp_s;
    logic [DIGITS-1:0][3:0]   pend_val_r, pend_val_s;
    logic [DIGITS-1:0]        pend_dp_r, pend_dp_s;
    logic                     pending_r, pending_s;
    logic [DIGITS-1:0][3:0]   value_s;

    logic                     slot_end_s;
    logic                     boundary_s;
    logic                     in_guard_s;
    logic [DIGITS-1:0]        lz_s;

    logic [3:0]               nibble_r, nibble_s;
    logic                     blank_r, blank_s;
    logic [DIGITS-1:0]        digit_en_n_r, digit_en_n_s;
    logic                     dp_n_r, dp_n_s;
    logic                     frame_tick_r;

    assign value_s    = value;
    assign slot_end_s = (presc_r == PRESC_LAST);
    assign boundary_s = slot_end_s && (idx_r == IDX_LAST);

    // Next-state for the slot timer, digit index and the staged/committed value pair.
    always_comb begin
        presc_s    = presc_r;
        idx_s      = idx_r;
        disp_val_s = disp_val_r;
        disp_dp_s  = disp_dp_r;
        pend_val_s = pend_val_r;
        pend_dp_s  = pend_dp_r;
        pending_s  = pending_r;

        if (slot_end_s) begin
            presc_s = '0;
            if (idx_r == IDX_LAST) begin
                idx_s = '0;
            end else begin
                idx_s = idx_r + IW'(1);
            end
        end else begin
            presc_s = presc_r + PW'(1);
        end

        if (load) begin
            pend_val_s = value_s;
            pend_dp_s  = dp_in;
        end else begin
            pend_val_s = pend_val_r;
            pend_dp_s  = pend_dp_r;
        end

        // A load landing on the boundary bypasses staging so the commit is immediate.
        if (boundary_s) begin
            pending_s = 1'b0;
            if (load) begin
                disp_val_s = value_s;
                disp_dp_s  = dp_in;
            end else if (pending_r) begin
                disp_val_s = pend_val_r;
                disp_dp_s  = pend_dp_r;
            end else begin
                disp_val_s = disp_val_r;
                disp_dp_s  = disp_dp_r;
            end
        end else if (load) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end
    end

    assign in_guard_s = (presc_r < GUARD_V);
    assign lz_s       = lz_mask(disp_val_r);

    // Output decode for the digit currently in its slot; guard cycles keep all anodes dark.
    always_comb begin
        nibble_s     = disp_val_r[idx_r];
        blank_s      = lz_s[idx_r] | in_guard_s;
        digit_en_n_s = '1;
        dp_n_s       = 1'b1;
        if (in_guard_s) begin
            digit_en_n_s = '1;
            dp_n_s       = 1'b1;
        end else begin
            digit_en_n_s[idx_r] = 1'b0;
            dp_n_s              = ~disp_dp_r[idx_r];
        end
    end

    // State and registered outputs; synchronous reset drops any coincident load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_r      <= '0;
            idx_r        <= '0;
            disp_val_r   <= '0;
            disp_dp_r    <= '0;
            pend_val_r   <= '0;
            pend_dp_r    <= '0;
            pending_r    <= 1'b0;
            nibble_r     <= 4'h0;
            blank_r      <= 1'b1;
            digit_en_n_r <= '1;
            dp_n_r       <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            presc_r      <= presc_s;
            idx_r        <= idx_s;
            disp_val_r   <= disp_val_s;
            disp_dp_r    <= disp_dp_s;
            pend_val_r   <= pend_val_s;
            pend_dp_r    <= pend_dp_s;
            pending_r    <= pending_s;
            nibble_r     <= nibble_s;
            blank_r      <= blank_s;
            digit_en_n_r <= digit_en_n_s;
            dp_n_r       <= dp_n_s;
            frame_tick_r <= boundary_s;
        end
    end

    assign nibble     = nibble_r;
    assign blank      = blank_r;
    assign digit_en_n = digit_en_n_r;
    assign dp_n       = dp_n_r;
    assign pending    = pending_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Multiplexed scan controller for a DIGITS-digit common-anode seven-segment (FND) display. Latches a hex value through a load strobe and commits it only at frame boundaries, so a frame never mixes old and new digits. Time-multiplexes one digit per refresh slot, with anode ghost-guard and optional leading-zero blanking. Sits directly upstream of the hex-to-segment decoder: `nibble` drives the decoder's 4-bit select, and `blank` gates the decoder output off.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `GUARD`, 16: cycles at the start of each slot with all anodes off; 0 ≤ GUARD < REFRESH_DIV.
- `BLANK_LZ`, 1: when 1, leading zeros are blanked.

- `clk`  in  1  sole clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `load`  in  1  one-cycle strobe that captures `value` and `dp_in`.
- `value`  in  4*DIGITS  hex value; nibble 0 (bits 3:0) is the rightmost digit.
- `dp_in`  in  DIGITS  decimal-point request per digit, active-high.
- `nibble`  out  4  hex code of the digit currently scanned, fed to the decoder.
- `blank`  out  1  1 forces the decoder output off (all segments dark).
- `digit_en_n`  out  DIGITS  one-hot-low anode enables; bit i drives digit i.
- `dp_n`  out  1  decimal point for the current digit, active-low.
- `pending`  out  1  a loaded value is waiting for the next frame boundary.
- `frame_tick`  out  1  one-cycle pulse when a frame boundary commit occurs.

## Operation
- State registers:
  - `presc`: counts 0..REFRESH_DIV-1 and wraps.
  - `idx`: current digit, 0..DIGITS-1, wraps.
  - `disp_val` / `disp_dp`: committed value and decimal points.
  - `pend_val` / `pend_dp`: staged value and decimal points.
  - `pending`: staged-value flag.
- `slot_end` is true when `presc == REFRESH_DIV-1`. On `slot_end`, `idx` increments and wraps to 0 after DIGITS-1.
- `boundary` is `slot_end` AND `idx == DIGITS-1`.
- Load:
  - `load=1` writes `pend_val` / `pend_dp` and sets `pending`.
  - Repeated loads before a boundary overwrite the staged value; the last load wins.
- Commit on `boundary`:
  - If `pending` or `load` is set: `disp_*` takes the staged value, or takes `value` / `dp_in` directly when `load` is 1 in that same cycle. `pending` clears to 0.
  - `frame_tick` pulses on every boundary, whether or not a commit happened.
- Leading-zero blanking: digit i > 0 is blank if BLANK_LZ=1 and nibbles i..DIGITS-1 of `disp_val` are all zero. Digit 0 is never LZ-blanked, so the value 0 shows a single "0".
- Per-cycle output, based on the current `idx` and `presc`:
  - `nibble` = `disp_val[idx]`.
  - `blank` = LZ-blank(idx) OR (`presc` < GUARD).
  - `digit_en_n` = all 1 while `presc` < GUARD; otherwise bit idx = 0 and all others = 1.
  - `dp_n` = ~`disp_dp[idx]` outside guard; 1 during guard.
  - Decimal points are not LZ-blanked; they follow `disp_dp` only.
- Reset (`rst_n=0` at a clock edge) applies regardless of any other input:
  - `presc`=0, `idx`=0, `disp_*`=0, `pend_*`=0, `pending`=0.
  - A `load` asserted in the same cycle as reset is discarded.

## Timing
- All outputs are registered and update one cycle after the internal state they reflect.
- Reset values: `nibble`=0, `blank`=1, `digit_en_n`=all 1, `dp_n`=1, `pending`=0, `frame_tick`=0.
- Slot length is REFRESH_DIV cycles; frame length is DIGITS*REFRESH_DIV cycles. Anodes are active for REFRESH_DIV-GUARD cycles per slot.
- `pending` rises the cycle after `load`. `frame_tick` and the new `disp_val` appear together, one cycle after the boundary edge.
- Worst-case load-to-display latency is DIGITS*REFRESH_DIV + 1 cycles. If `load` coincides with the boundary, latency is 1 cycle and `pending` never rises.
- At most one anode is low in any cycle. No two anodes are ever low across a digit change: guard cycles separate them, and with GUARD=0 the handoff happens in a single registered edge.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, GUARD=1.
- **Reset:** hold `rst_n`=0 for 3 cycles → `digit_en_n`=4'b1111, `blank`=1, `dp_n`=1, `pending`=0; 1 cycle after release the first active slot drives `digit_en_n`=4'b1110.
- **Scan order:** load 16'h1234, no dp → after the commit, each 4-cycle slot shows 1 guard cycle with all anodes off, then 3 cycles of nibble 4/3/2/1 with `digit_en_n` 1110/1101/1011/0111; `frame_tick` every 16 cycles.
- **Staging:** load 16'hABCD mid-frame, then 16'h00F0 two cycles later → `pending`=1 until the boundary; the next frame shows 00F0, never ABCD; `frame_tick` coincides with `pending` falling.
- **Simultaneous load and boundary:** load 16'h5678 exactly on the boundary cycle → the next frame shows 5678 and `pending` stays 0 throughout.
- **Leading-zero blanking:** load 16'h0070 with BLANK_LZ=1 → digits 3 and 2 have `blank`=1, digit 1 shows 7, digit 0 shows 0. Load 16'h0000 → only digit 0 is unblanked. Load with `dp_in`=4'b0100 → `dp_n`=0 only in the digit-2 active cycles, even though digit 2 is blank.
- **Reset mid-operation:** assert `rst_n`=0 during slot 2 with `pending`=1 → all state clears; after release the display shows 0 on digit 0 and `pending`=0.
